// File: rtl/transmisor_resultado_filtro.sv
// ---------------------------------------------------------------------------
// transmisor_resultado_filtro
//
// Takes the filter result on the controller's one-cycle i_listo pulse and sends
// it over a UART 8N1 line: DW/8 bytes, most-significant byte first, each byte
// LSB first. The bit period is generated internally from BIT_CYCLES, so no
// external baud tick is needed. A one-cycle done tick marks the end of the
// frame, and a one-cycle o_perdido pulse flags every result that arrives
// while a frame is still being sent (that result is dropped).
//
// Ports
//   i_clk           system clock, rising edge
//   i_reset         synchronous reset, active-high; aborts any frame
//   i_listo         one-cycle pulse: i_dato is valid
//   i_dato[DW-1:0]  filter result, sampled only when i_listo is accepted
//   o_tx            serial line, idles high
//   o_tx_busy       high from the cycle after acceptance until the frame ends
//   o_tx_done_tick  one-cycle pulse on the first idle cycle after the frame
//   o_perdido       one-cycle pulse the cycle after an ignored i_listo
//
// All outputs are registered.
//
// State | Meaning
// ------+-----------------------------------------------------------------
// IDLE  | line high, waiting for i_listo
// START | start bit (line low) for BIT_CYCLES cycles
// DATA  | data bit r_bit of the current byte, BIT_CYCLES cycles per bit
// STOP  | stop bit (line high); then next byte's START or back to IDLE
// ---------------------------------------------------------------------------
module transmisor_resultado_filtro #(
    parameter int DW         = 16,
    parameter int BIT_CYCLES = 2604
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_listo,
    input  logic [DW-1:0] i_dato,
    output logic          o_tx,
    output logic          o_tx_busy,
    output logic          o_tx_done_tick,
    output logic          o_perdido
);

    localparam int NBYTES = DW / 8;
    localparam int CNT_W  = $clog2(BIT_CYCLES);
    localparam int BYTE_W = $clog2(NBYTES) + 1;

    // The bit timer is a down-counter reloaded with BIT_CYCLES-1 at the start
    // of every bit; the bit ends on the cycle it reads zero.
    localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(BIT_CYCLES - 1);
    localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(NBYTES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t              r_state, w_state_n;
    logic [DW-1:0]       r_shift, w_shift_n;
    logic [CNT_W-1:0]    r_cnt,   w_cnt_n;
    logic [2:0]          r_bit,   w_bit_n;
    logic [BYTE_W-1:0]   r_byte,  w_byte_n;
    logic                r_tx,    w_tx_n;
    logic                r_busy,  w_busy_n;
    logic                r_done,  w_done_n;
    logic                r_perdido, w_perdido_n;

    // The byte being sent always sits in the top 8 bits of the shift register.
    logic [7:0]          w_byte_actual;
    logic                w_fin_bit;

    assign w_byte_actual = r_shift[DW-1 -: 8];
    assign w_fin_bit     = (r_cnt == '0);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= S_IDLE;
            r_shift   <= '0;
            r_cnt     <= '0;
            r_bit     <= '0;
            r_byte    <= '0;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_perdido <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_shift   <= w_shift_n;
            r_cnt     <= w_cnt_n;
            r_bit     <= w_bit_n;
            r_byte    <= w_byte_n;
            r_tx      <= w_tx_n;
            r_busy    <= w_busy_n;
            r_done    <= w_done_n;
            r_perdido <= w_perdido_n;
        end
    end

    always_comb begin
        w_state_n   = r_state;
        w_shift_n   = r_shift;
        w_cnt_n     = r_cnt;
        w_bit_n     = r_bit;
        w_byte_n    = r_byte;
        w_tx_n      = r_tx;
        w_busy_n    = r_busy;
        w_done_n    = 1'b0;
        // Any listo seen outside IDLE is dropped and reported.
        w_perdido_n = i_listo && (r_state != S_IDLE);

        case (r_state)
            S_IDLE: begin
                w_tx_n   = 1'b1;
                w_busy_n = 1'b0;
                if (i_listo) begin
                    w_shift_n = i_dato;
                    w_cnt_n   = CNT_LOAD;
                    w_bit_n   = '0;
                    w_byte_n  = '0;
                    w_tx_n    = 1'b0;
                    w_busy_n  = 1'b1;
                    w_state_n = S_START;
                end
            end

            S_START: begin
                if (w_fin_bit) begin
                    w_cnt_n   = CNT_LOAD;
                    w_bit_n   = '0;
                    w_tx_n    = w_byte_actual[0];
                    w_state_n = S_DATA;
                end else begin
                    w_cnt_n = r_cnt - CNT_W'(1);
                end
            end

            S_DATA: begin
                if (w_fin_bit) begin
                    w_cnt_n = CNT_LOAD;
                    if (r_bit == 3'd7) begin
                        w_tx_n    = 1'b1;
                        w_state_n = S_STOP;
                    end else begin
                        w_bit_n = r_bit + 3'd1;
                        w_tx_n  = w_byte_actual[r_bit + 3'd1];
                    end
                end else begin
                    w_cnt_n = r_cnt - CNT_W'(1);
                end
            end

            S_STOP: begin
                if (w_fin_bit) begin
                    if (r_byte == LAST_BYTE) begin
                        w_tx_n    = 1'b1;
                        w_busy_n  = 1'b0;
                        w_done_n  = 1'b1;
                        w_state_n = S_IDLE;
                    end else begin
                        // Next byte starts right away, no idle gap on the line.
                        w_shift_n = r_shift << 8;
                        w_byte_n  = r_byte + BYTE_W'(1);
                        w_cnt_n   = CNT_LOAD;
                        w_tx_n    = 1'b0;
                        w_state_n = S_START;
                    end
                end else begin
                    w_cnt_n = r_cnt - CNT_W'(1);
                end
            end

            default: begin
                w_state_n = S_IDLE;
                w_tx_n    = 1'b1;
                w_busy_n  = 1'b0;
            end
        endcase
    end

    assign o_tx           = r_tx;
    assign o_tx_busy      = r_busy;
    assign o_tx_done_tick = r_done;
    assign o_perdido      = r_perdido;

endmodule

// File: tb/tb_transmisor_resultado_filtro.sv
module tb_transmisor_resultado_filtro;

    localparam int DW  = 16;
    localparam int BC  = 4;
    localparam int NB  = DW / 8;
    localparam int L   = NB * 10 * BC;

    localparam int DWB = 8;
    localparam int BCB = 2604;
    localparam int LB  = (DWB / 8) * 10 * BCB;

    typedef bit bitq_t[$];

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, listo;
    logic [DW-1:0] dato;
    logic          tx, tx_busy, tx_done_tick, perdido;

    logic           reset_b, listo_b;
    logic [DWB-1:0] dato_b;
    logic           tx_b, tx_busy_b, tx_done_tick_b, perdido_b;

    int n_assert = 0;
    int n_fail   = 0;

    transmisor_resultado_filtro #(.DW(DW), .BIT_CYCLES(BC)) dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_listo        (listo),
        .i_dato         (dato),
        .o_tx           (tx),
        .o_tx_busy      (tx_busy),
        .o_tx_done_tick (tx_done_tick),
        .o_perdido      (perdido)
    );

    transmisor_resultado_filtro #(.DW(DWB), .BIT_CYCLES(BCB)) dut_b (
        .i_clk          (clk),
        .i_reset        (reset_b),
        .i_listo        (listo_b),
        .i_dato         (dato_b),
        .o_tx           (tx_b),
        .o_tx_busy      (tx_busy_b),
        .o_tx_done_tick (tx_done_tick_b),
        .o_perdido      (perdido_b)
    );

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    // Expected line level for every cycle of a frame, built from the UART
    // rules: per byte (MSB byte first) a 0 start bit, 8 data bits LSB first,
    // a 1 stop bit, each repeated bc times.
    function automatic bitq_t frame_bits(input logic [31:0] d, input int nb, input int bc);
        bitq_t q;
        for (int k = 0; k < nb; k++) begin
            int byte_v;
            byte_v = int'((d >> (8 * (nb - 1 - k))) & 32'hFF);
            for (int p = 0; p < 10; p++) begin
                bit b;
                if (p == 0)      b = 1'b0;
                else if (p == 9) b = 1'b1;
                else             b = bit'((byte_v >> (p - 1)) & 1);
                for (int c = 0; c < bc; c++) q.push_back(b);
            end
        end
        return q;
    endfunction

    task automatic idle_check(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            listo = 1'b0;
            dato  = DW'($urandom);
            @(negedge clk);
            chk($sformatf("%s.tx[%0d]", tag, i), tx, 1'b1);
            chk($sformatf("%s.busy[%0d]", tag, i), tx_busy, 1'b0);
            chk($sformatf("%s.done[%0d]", tag, i), tx_done_tick, 1'b0);
            chk($sformatf("%s.perdido[%0d]", tag, i), perdido, 1'b0);
            chk($sformatf("%s.b_tx[%0d]", tag, i), tx_b, 1'b1);
            chk($sformatf("%s.b_busy[%0d]", tag, i), tx_busy_b, 1'b0);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic kick(input logic [DW-1:0] d);
        listo = 1'b1;
        dato  = d;
        @(posedge clk);
        #1;
        listo = 1'b0;
    endtask

    // Checks one frame cycle by cycle, starting the cycle after acceptance.
    // lost_at/lost_len: listo pulses injected mid-frame (must be ignored).
    // abort_at: cycle where reset and listo are raised together.
    // chain: a new listo in the done-tick cycle with chain_d.
    task automatic run_frame(input logic [DW-1:0] d, input int lost_at, input int lost_len,
                             input int abort_at, input bit chain, input logic [DW-1:0] chain_d);
        bitq_t q;
        q = frame_bits(32'(d), NB, BC);
        for (int j = 0; j <= L; j++) begin
            listo = 1'b0;
            dato  = DW'($urandom);
            if (j >= lost_at && j < lost_at + lost_len) listo = 1'b1;
            if (j == L && chain) begin
                listo = 1'b1;
                dato  = chain_d;
            end
            if (j == abort_at) begin
                reset = 1'b1;
                listo = 1'b1;
            end
            @(negedge clk);
            chk($sformatf("tx[%0d]", j), tx, (j < L) ? logic'(q[j]) : 1'b1);
            chk($sformatf("busy[%0d]", j), tx_busy, logic'(j < L));
            chk($sformatf("done[%0d]", j), tx_done_tick, logic'(j == L));
            chk($sformatf("perdido[%0d]", j), perdido,
                logic'(j > lost_at && j <= lost_at + lost_len));
            @(posedge clk);
            #1;
            if (j == abort_at) begin
                reset = 1'b0;
                listo = 1'b0;
                @(negedge clk);
                chk("abort.tx", tx, 1'b1);
                chk("abort.busy", tx_busy, 1'b0);
                chk("abort.done", tx_done_tick, 1'b0);
                chk("abort.perdido", perdido, 1'b0);
                @(posedge clk);
                #1;
                break;
            end
        end
        listo = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] d, nd;
        bit            pending, chain;
        int            lost_at, lost_len;
        bitq_t         qb;

        reset   = 1'b1;
        listo   = 1'b0;
        dato    = '0;
        reset_b = 1'b1;
        listo_b = 1'b0;
        dato_b  = '0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset   = 1'b0;
        reset_b = 1'b0;

        idle_check(20, "reset_idle");

        // A53C frame, then 0001 accepted in the done-tick cycle.
        kick(16'hA53C);
        run_frame(16'hA53C, -1, 0, -1, 1'b1, 16'h0001);
        run_frame(16'h0001, -1, 0, -1, 1'b0, '0);
        idle_check(3, "after_chain");

        // Single lost listo 30 cycles in, then two back-to-back lost pulses.
        d = DW'($urandom);
        kick(d);
        run_frame(d, 30, 1, -1, 1'b0, '0);
        idle_check(2, "after_lost");
        d = DW'($urandom);
        kick(d);
        run_frame(d, 10, 2, -1, 1'b0, '0);
        idle_check(2, "after_lost2");

        // Reset (with a simultaneous listo) 45 cycles in; then a clean frame.
        d = DW'($urandom);
        kick(d);
        run_frame(d, -1, 0, 45, 1'b0, '0);
        idle_check(5, "after_abort");
        d = DW'($urandom);
        kick(d);
        run_frame(d, -1, 0, -1, 1'b0, '0);

        // Reset and listo together while idle: nothing is captured.
        reset = 1'b1;
        listo = 1'b1;
        dato  = DW'($urandom);
        @(posedge clk);
        #1;
        reset = 1'b0;
        listo = 1'b0;
        idle_check(4, "reset_listo_idle");

        // Random frames with random lost pulses and random chaining.
        pending = 1'b0;
        d       = DW'($urandom);
        for (int it = 0; it < 8; it++) begin
            if (!pending) kick(d);
            chain = (it != 7) && ($urandom_range(0, 1) == 1);
            nd    = DW'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                lost_at  = $urandom_range(0, L - 3);
                lost_len = $urandom_range(1, 2);
            end else begin
                lost_at  = -1;
                lost_len = 0;
            end
            run_frame(d, lost_at, lost_len, -1, chain, nd);
            pending = chain;
            d       = chain ? nd : DW'($urandom);
        end
        idle_check(2, "after_random");

        // DW=8, BIT_CYCLES=2604 instance with 8'h55.
        listo_b = 1'b1;
        dato_b  = 8'h55;
        @(posedge clk);
        #1;
        listo_b = 1'b0;
        qb = frame_bits(32'h55, 1, BCB);
        for (int j = 0; j <= LB; j++) begin
            dato_b = DWB'($urandom);
            @(negedge clk);
            chk($sformatf("b.tx[%0d]", j), tx_b, (j < LB) ? logic'(qb[j]) : 1'b1);
            chk($sformatf("b.busy[%0d]", j), tx_busy_b, logic'(j < LB));
            chk($sformatf("b.done[%0d]", j), tx_done_tick_b, logic'(j == LB));
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk("b.done_after", tx_done_tick_b, 1'b0);
        chk("b.tx_after", tx_b, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
